// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, default widths
// and the MEM->WB stage state encoding.
package mips_pipe_pkg;

   localparam int CTRL_MEMTOREG = 0;
   localparam int CTRL_REGWRITE = 1;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 5;
   localparam int DEF_CTRL_W = 2;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_TWO
   } stage_state_e;

   // Number of held entries implied by a stage state.
   function automatic logic [1:0] state_occupancy(input stage_state_e s);
      case (s)
         ST_ONE:  return 2'd1;
         ST_TWO:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_wb_stage_hs_if.sv
// Handshake bus of the MEM->WB stage: upstream valid/ready with payload,
// downstream valid/ready with the selected write-back result.
interface mem_wb_stage_hs_if
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW,
   parameter int CTRL_W = DEF_CTRL_W
) ();

   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_rdata;
   logic [DATA_W-1:0] in_alu;
   logic [REG_AW-1:0] in_wreg;

   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [REG_AW-1:0] out_wreg;
   logic [DATA_W-1:0] out_wb_data;
   logic              out_regwe;

   modport slave (
      input  in_valid, in_ctrl, in_rdata, in_alu, in_wreg, out_ready,
      output in_ready, out_valid, out_ctrl, out_wreg, out_wb_data, out_regwe
   );

   modport master (
      output in_valid, in_ctrl, in_rdata, in_alu, in_wreg, out_ready,
      input  in_ready, out_valid, out_ctrl, out_wreg, out_wb_data, out_regwe
   );

endinterface

// File: rtl/pipe_payload_reg.sv
// One MEM->WB payload slot (control, read data, ALU result, destination)
// with load enable and asynchronous clear.
module pipe_payload_reg
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW,
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [DATA_W-1:0] i_alu,
   input  logic [REG_AW-1:0] i_wreg,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_rdata,
   output logic [DATA_W-1:0] o_alu,
   output logic [REG_AW-1:0] o_wreg
);

   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_alu;
   logic [REG_AW-1:0] r_wreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl  <= '0;
         r_rdata <= '0;
         r_alu   <= '0;
         r_wreg  <= '0;
      end else if (i_load) begin
         r_ctrl  <= i_ctrl;
         r_rdata <= i_rdata;
         r_alu   <= i_alu;
         r_wreg  <= i_wreg;
      end
   end

   assign o_ctrl  = r_ctrl;
   assign o_rdata = r_rdata;
   assign o_alu   = r_alu;
   assign o_wreg  = r_wreg;

endmodule

// File: rtl/mem_wb_stage_hs.sv
// MEM->WB pipeline stage with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and the MemtoReg write-back mux.
module mem_wb_stage_hs
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int SKID   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   mem_wb_stage_hs_if.slave   bus,
   output logic [1:0]         occupancy
);

   stage_state_e r_state;
   stage_state_e w_state_next;

   logic w_push;
   logic w_pop;
   logic w_out_valid;
   logic w_main_load;
   logic w_skid_load;
   logic w_main_from_skid;

   logic [CTRL_W-1:0] w_main_ctrl,  w_skid_ctrl,  w_src_ctrl;
   logic [DATA_W-1:0] w_main_rdata, w_skid_rdata, w_src_rdata;
   logic [DATA_W-1:0] w_main_alu,   w_skid_alu,   w_src_alu;
   logic [REG_AW-1:0] w_main_wreg,  w_skid_wreg,  w_src_wreg;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_push      = bus.in_valid & bus.in_ready;
   assign w_pop       = w_out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Without the skid slot a push in ONE always coincides with a pop,
   // because ready is only offered when the head is leaving.
   always_comb begin
      w_state_next     = r_state;
      w_main_load      = 1'b0;
      w_skid_load      = 1'b0;
      w_main_from_skid = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_state_next = ST_ONE;
               w_main_load  = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_push && w_pop) begin
               w_main_load  = 1'b1;
            end else if (w_push) begin
               w_state_next = ST_TWO;
               w_skid_load  = 1'b1;
            end else if (w_pop) begin
               w_state_next = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_pop) begin
               w_state_next     = ST_ONE;
               w_main_load      = 1'b1;
               w_main_from_skid = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_EMPTY;
         end
      endcase
      // Flush drops every entry, including one being pushed; payloads keep old values.
      if (flush) begin
         w_state_next = ST_EMPTY;
         w_main_load  = 1'b0;
         w_skid_load  = 1'b0;
      end
   end

   assign w_src_ctrl  = w_main_from_skid ? w_skid_ctrl  : bus.in_ctrl;
   assign w_src_rdata = w_main_from_skid ? w_skid_rdata : bus.in_rdata;
   assign w_src_alu   = w_main_from_skid ? w_skid_alu   : bus.in_alu;
   assign w_src_wreg  = w_main_from_skid ? w_skid_wreg  : bus.in_wreg;

   pipe_payload_reg #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_main_load),
      .i_ctrl  (w_src_ctrl),
      .i_rdata (w_src_rdata),
      .i_alu   (w_src_alu),
      .i_wreg  (w_src_wreg),
      .o_ctrl  (w_main_ctrl),
      .o_rdata (w_main_rdata),
      .o_alu   (w_main_alu),
      .o_wreg  (w_main_wreg)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic r_in_ready;

         pipe_payload_reg #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .CTRL_W (CTRL_W)
         ) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_skid_load),
            .i_ctrl  (bus.in_ctrl),
            .i_rdata (bus.in_rdata),
            .i_alu   (bus.in_alu),
            .i_wreg  (bus.in_wreg),
            .o_ctrl  (w_skid_ctrl),
            .o_rdata (w_skid_rdata),
            .o_alu   (w_skid_alu),
            .o_wreg  (w_skid_wreg)
         );

         // Ready is a flop so the upstream never sees a path from out_ready.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_in_ready <= 1'b0;
            end else begin
               r_in_ready <= (w_state_next != ST_TWO);
            end
         end

         assign bus.in_ready = r_in_ready;
      end else begin : g_noskid
         logic r_rst_done;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rst_done <= 1'b0;
            end else begin
               r_rst_done <= 1'b1;
            end
         end

         assign bus.in_ready = r_rst_done & (!w_out_valid | bus.out_ready);
         assign w_skid_ctrl  = '0;
         assign w_skid_rdata = '0;
         assign w_skid_alu   = '0;
         assign w_skid_wreg  = '0;
      end
   endgenerate

   assign bus.out_valid   = w_out_valid;
   assign bus.out_ctrl    = w_main_ctrl;
   assign bus.out_wreg    = w_main_wreg;
   assign bus.out_wb_data = w_main_ctrl[CTRL_MEMTOREG] ? w_main_rdata : w_main_alu;
   // $zero is hard-wired, so a write to register 0 is suppressed here.
   assign bus.out_regwe   = w_out_valid & w_main_ctrl[CTRL_REGWRITE] & (w_main_wreg != '0);
   assign occupancy       = state_occupancy(r_state);

endmodule

// File: tb/tb_mem_wb_stage_hs.sv
// Directed, table-driven bench for mem_wb_stage_hs: SKID=1 instance (dut_a)
// and SKID=0 instance (dut_b), plus hand sequences for reset and ready timing.
module tb_mem_wb_stage_hs;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush_a, flush_b;
   logic [1:0] occ_a, occ_b;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_wb_stage_hs_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(2)) ifa ();
   mem_wb_stage_hs_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(2)) ifb ();

   mem_wb_stage_hs #(.DATA_W(32), .REG_AW(5), .CTRL_W(2), .SKID(1)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_a),
      .bus       (ifa),
      .occupancy (occ_a)
   );

   mem_wb_stage_hs #(.DATA_W(32), .REG_AW(5), .CTRL_W(2), .SKID(0)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_b),
      .bus       (ifb),
      .occupancy (occ_b)
   );

   typedef struct packed {
      logic        v;
      logic [1:0]  ctrl;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  wreg;
      logic        ordy;
      logic        fl;
      logic        e_valid;
      logic [31:0] e_wb;
      logic        e_we;
      logic [1:0]  e_occ;
      logic        e_irdy;
   } vec_t;

   vec_t tab_a [24];
   vec_t tab_b [4];

   function automatic vec_t mk(input logic v, input logic [1:0] ctrl, input logic [31:0] rdata,
                               input logic [31:0] alu, input logic [4:0] wreg, input logic ordy,
                               input logic fl, input logic e_valid, input logic [31:0] e_wb,
                               input logic e_we, input logic [1:0] e_occ, input logic e_irdy);
      vec_t r;
      r.v = v; r.ctrl = ctrl; r.rdata = rdata; r.alu = alu; r.wreg = wreg;
      r.ordy = ordy; r.fl = fl; r.e_valid = e_valid; r.e_wb = e_wb;
      r.e_we = e_we; r.e_occ = e_occ; r.e_irdy = e_irdy;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_all();
      ifa.in_valid = 1'b0; ifa.in_ctrl = '0; ifa.in_rdata = '0; ifa.in_alu = '0;
      ifa.in_wreg = '0; ifa.out_ready = 1'b1; flush_a = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_ctrl = '0; ifb.in_rdata = '0; ifb.in_alu = '0;
      ifb.in_wreg = '0; ifb.out_ready = 1'b1; flush_b = 1'b0;
   endtask

   task automatic check_out(input string tag, input int which, input logic e_valid,
                            input logic [31:0] e_wb, input logic e_we, input logic [1:0] e_occ,
                            input logic e_irdy);
      logic        a_valid, a_we, a_irdy;
      logic [31:0] a_wb;
      logic [1:0]  a_occ;
      if (which == 0) begin
         a_valid = ifa.out_valid; a_wb = ifa.out_wb_data; a_we = ifa.out_regwe;
         a_occ = occ_a; a_irdy = ifa.in_ready;
      end else begin
         a_valid = ifb.out_valid; a_wb = ifb.out_wb_data; a_we = ifb.out_regwe;
         a_occ = occ_b; a_irdy = ifb.in_ready;
      end
      chk({tag, " out_valid"},   {31'b0, a_valid}, {31'b0, e_valid});
      chk({tag, " out_wb_data"}, a_wb,             e_wb);
      chk({tag, " out_regwe"},   {31'b0, a_we},    {31'b0, e_we});
      chk({tag, " occupancy"},   {30'b0, a_occ},   {30'b0, e_occ});
      chk({tag, " in_ready"},    {31'b0, a_irdy},  {31'b0, e_irdy});
      $display("tx %s: valid=%0b wb=%h regwe=%0b occ=%0d in_ready=%0b",
               tag, a_valid, a_wb, a_we, a_occ, a_irdy);
   endtask

   task automatic apply(input vec_t t, input int which, input int idx);
      if (which == 0) begin
         ifa.in_valid = t.v; ifa.in_ctrl = t.ctrl; ifa.in_rdata = t.rdata;
         ifa.in_alu = t.alu; ifa.in_wreg = t.wreg; ifa.out_ready = t.ordy; flush_a = t.fl;
      end else begin
         ifb.in_valid = t.v; ifb.in_ctrl = t.ctrl; ifb.in_rdata = t.rdata;
         ifb.in_alu = t.alu; ifb.in_wreg = t.wreg; ifb.out_ready = t.ordy; flush_b = t.fl;
      end
      @(posedge clk);
      #1;
      check_out($sformatf("%s_v%0d", (which == 0) ? "skid1" : "skid0", idx), which,
                t.e_valid, t.e_wb, t.e_we, t.e_occ, t.e_irdy);
   endtask

   initial begin
      // SKID=1: streaming, back-pressure, mux/guard, flush
      for (int i = 0; i < 8; i++)
         tab_a[i] = mk(1, 2'b10, 32'h0, 32'(32'h10 + i), 5'(i + 1), 1, 0,
                       1, 32'(32'h10 + i), 1, 2'd1, 1);
      tab_a[8]  = mk(0, 2'b00, 32'h0, 32'h0,         5'd0, 1, 0, 0, 32'h0000_0017, 0, 2'd0, 1);
      tab_a[9]  = mk(1, 2'b10, 32'h0, 32'hAAAA_0001, 5'd3, 0, 0, 1, 32'hAAAA_0001, 1, 2'd1, 1);
      tab_a[10] = mk(1, 2'b10, 32'h0, 32'hBBBB_0002, 5'd4, 0, 0, 1, 32'hAAAA_0001, 1, 2'd2, 0);
      tab_a[11] = mk(1, 2'b10, 32'h0, 32'hCCCC_0003, 5'd9, 0, 0, 1, 32'hAAAA_0001, 1, 2'd2, 0);
      tab_a[12] = mk(0, 2'b00, 32'h0, 32'h0,         5'd0, 1, 0, 1, 32'hBBBB_0002, 1, 2'd1, 1);
      tab_a[13] = mk(0, 2'b00, 32'h0, 32'h0,         5'd0, 1, 0, 0, 32'hBBBB_0002, 0, 2'd0, 1);
      tab_a[14] = mk(1, 2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5, 0, 0,
                     1, 32'hDEAD_BEEF, 1, 2'd1, 1);
      tab_a[15] = mk(1, 2'b10, 32'h0, 32'h0000_0055, 5'd0, 1, 0, 1, 32'h0000_0055, 0, 2'd1, 1);
      tab_a[16] = mk(0, 2'b00, 32'h0, 32'h0,         5'd0, 1, 0, 0, 32'h0000_0055, 0, 2'd0, 1);
      tab_a[17] = mk(1, 2'b10, 32'h0, 32'h0000_00D0, 5'd6, 0, 0, 1, 32'h0000_00D0, 1, 2'd1, 1);
      tab_a[18] = mk(1, 2'b10, 32'h0, 32'h0000_00E0, 5'd7, 0, 0, 1, 32'h0000_00D0, 1, 2'd2, 0);
      tab_a[19] = mk(1, 2'b10, 32'h0, 32'h0000_C0C0, 5'd9, 0, 1, 0, 32'h0000_00D0, 0, 2'd0, 1);
      tab_a[20] = mk(0, 2'b00, 32'h0, 32'h0,         5'd0, 1, 0, 0, 32'h0000_00D0, 0, 2'd0, 1);
      tab_a[21] = mk(1, 2'b10, 32'h0, 32'h0000_00F0, 5'd6, 0, 0, 1, 32'h0000_00F0, 1, 2'd1, 1);
      tab_a[22] = mk(1, 2'b10, 32'h0, 32'h0000_0060, 5'd7, 1, 1, 0, 32'h0000_00F0, 0, 2'd0, 1);
      tab_a[23] = mk(0, 2'b00, 32'h0, 32'h0,         5'd0, 1, 0, 0, 32'h0000_00F0, 0, 2'd0, 1);

      // SKID=0: single entry, stall blocks further pushes, push+pop reloads
      tab_b[0] = mk(1, 2'b10, 32'h0, 32'h0000_0100, 5'd2, 0, 0, 1, 32'h0000_0100, 1, 2'd1, 0);
      tab_b[1] = mk(1, 2'b10, 32'h0, 32'h0000_0200, 5'd3, 0, 0, 1, 32'h0000_0100, 1, 2'd1, 0);
      tab_b[2] = mk(1, 2'b11, 32'hCAFE_F00D, 32'h0000_0007, 5'd5, 1, 0,
                    1, 32'hCAFE_F00D, 1, 2'd1, 1);
      tab_b[3] = mk(1, 2'b10, 32'h0, 32'h0000_0400, 5'd6, 0, 0, 1, 32'hCAFE_F00D, 1, 2'd1, 0);

      // Power-on reset
      idle_all();
      rst_n = 1'b0;
      #12;
      check_out("por_a", 0, 0, 32'h0, 0, 2'd0, 0);
      check_out("por_b", 1, 0, 32'h0, 0, 2'd0, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_out("rel_a", 0, 0, 32'h0, 0, 2'd0, 1);
      check_out("rel_b", 1, 0, 32'h0, 0, 2'd0, 1);

      for (int i = 0; i < 24; i++) apply(tab_a[i], 0, i);
      idle_all();
      for (int i = 0; i < 4; i++) apply(tab_b[i], 1, i);

      // SKID=0 ready follows out_ready within the same cycle
      ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
      #1;
      chk("skid0 comb in_ready low", {31'b0, ifb.in_ready}, 32'd0);
      ifb.in_valid = 1'b1; ifb.in_ctrl = 2'b10; ifb.in_alu = 32'h0000_0300;
      ifb.in_wreg = 5'd4; ifb.out_ready = 1'b1;
      #1;
      chk("skid0 comb in_ready high", {31'b0, ifb.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check_out("skid0_reload", 1, 1, 32'h0000_0300, 1, 2'd1, 1);
      ifb.in_alu = 32'h0000_0999; flush_b = 1'b1;
      @(posedge clk);
      #1;
      check_out("skid0_flush", 1, 0, 32'h0000_0300, 0, 2'd0, 1);
      idle_all();

      // Asynchronous reset with two entries held
      ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.in_ctrl = 2'b10;
      ifa.in_alu = 32'h0000_0077; ifa.in_wreg = 5'd1;
      @(posedge clk);
      #1;
      ifa.in_alu = 32'h0000_0088; ifa.in_wreg = 5'd2;
      @(posedge clk);
      #1;
      check_out("pre_rst_a", 0, 1, 32'h0000_0077, 1, 2'd2, 0);
      ifa.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_out("async_rst_a", 0, 0, 32'h0, 0, 2'd0, 0);
      #2 rst_n = 1'b1;
      ifa.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_out("post_rst_a", 0, 0, 32'h0, 0, 2'd0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
